cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) between NUM_REQ functional-unit result ports.

---
 rtl/cdb_arbiter_if.sv | 27 ++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus interface: functional-unit result requests and the CDB broadcast.
// The master side is the set of functional units (plus CDB consumers);
// the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*TAG_W-1:0]   req_tag;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_tag;
    logic [DATA_W-1:0]          cdb_data;
    logic [$clog2(NUM_REQ)-1:0] cdb_src;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks at most one pending functional-unit result per cycle and
// broadcasts {tag, data, source} on a registered common data bus.
// Default policy is round-robin. Defining CDB_AGE_PRIO_EN switches to
// oldest-ROB-tag-first, with age measured relative to i_rob_head.
module cdb_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_rob_head,
    cdb_arbiter_if.slave     bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic             w_anyGrant;
    logic [IDX_W-1:0] w_grantIdx;
    logic             w_doGrant;
    logic             w_headTerm;

    logic             r_cdbValid;
    logic [TAG_W-1:0] r_cdbTag;
    logic [DATA_W-1:0] r_cdbData;
    logic [IDX_W-1:0] r_cdbSrc;

`ifdef CDB_AGE_PRIO_EN
    logic [TAG_W-1:0] w_age;
    logic [TAG_W-1:0] w_bestAge;

    // Oldest-first: smallest (tag - head) wins, strict compare keeps the lowest index on ties
    always_comb begin
        w_anyGrant = 1'b0;
        w_grantIdx = '0;
        w_bestAge  = '0;
        w_age      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_age = bus.req_tag[i*TAG_W +: TAG_W] - i_rob_head;
            if (bus.req_valid[i] && (!w_anyGrant || (w_age < w_bestAge))) begin
                w_anyGrant = 1'b1;
                w_grantIdx = IDX_W'(i);
                w_bestAge  = w_age;
            end
        end
    end

    assign w_headTerm = 1'b1;
`else
    logic [IDX_W-1:0] r_rrPtr;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Round-robin: first valid request searching upward from r_rrPtr, wrapping at NUM_REQ
    always_comb begin
        w_anyGrant = 1'b0;
        w_grantIdx = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_anyGrant && bus.req_valid[w_idx]) begin
                w_anyGrant = 1'b1;
                w_grantIdx = w_idx;
            end
        end
    end

    // The ROB head plays no part in round-robin; it folds into a constant-true term
    // so the port keeps a reader while tied off.
    assign w_headTerm = |{1'b1, i_rob_head};

    // Pointer advances past the granted index; flush or idle cycles leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else if (w_doGrant) begin
            if (w_grantIdx == IDX_W'(NUM_REQ - 1)) begin
                r_rrPtr <= '0;
            end else begin
                r_rrPtr <= w_grantIdx + 1'b1;
            end
        end
    end
`endif

    // The bus never stalls, so any pending request is granted unless flush or reset blocks it
    assign w_doGrant     = w_anyGrant & ~i_flush & ~rst & w_headTerm;
    assign bus.req_ready = w_doGrant ? (NUM_REQ'(1) << w_grantIdx) : '0;

    // Broadcast register: valid for one cycle per grant; payload holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdbValid <= 1'b0;
            r_cdbTag   <= '0;
            r_cdbData  <= '0;
            r_cdbSrc   <= '0;
        end else begin
            r_cdbValid <= w_doGrant;
            if (w_doGrant) begin
                r_cdbTag  <= bus.req_tag[w_grantIdx*TAG_W +: TAG_W];
                r_cdbData <= bus.req_data[w_grantIdx*DATA_W +: DATA_W];
                r_cdbSrc  <= w_grantIdx;
            end
        end
    end

    assign bus.cdb_valid = r_cdbValid;
    assign bus.cdb_tag   = r_cdbTag;
    assign bus.cdb_data  = r_cdbData;
    assign bus.cdb_src   = r_cdbSrc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter. A small reference model predicts each grant when a
// request pattern is driven and queues the expected broadcast; the broadcast is
// checked one cycle later when it appears on the CDB.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 8;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;

    typedef struct packed {
        logic        valid;
        logic [2:0]  tag;
        logic [31:0] data;
        logic [2:0]  src;
    } expEntry_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] robHead;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_rob_head (robHead),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    expEntry_t   scoreboard[$];
    logic [2:0]  tagOf[NUM_REQ];
    logic [31:0] dataOf[NUM_REQ];
    int          mdlRr;
    logic [2:0]  mdlTag;
    logic [31:0] mdlData;
    logic [2:0]  mdlSrc;

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Reference grant choice for a request vector
    function automatic int modelGrant(input logic [7:0] v);
        int best;
`ifdef CDB_AGE_PRIO_EN
        logic [2:0] age;
        logic [2:0] bestAge;
        best = -1;
        bestAge = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age = tagOf[i] - robHead;
            if (v[i] && (best < 0 || age < bestAge)) begin
                best = i;
                bestAge = age;
            end
        end
`else
        best = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (best < 0 && v[(mdlRr + k) % NUM_REQ]) best = (mdlRr + k) % NUM_REQ;
        end
`endif
        return best;
    endfunction

    // Pop the expectation for the broadcast now on the CDB and compare it
    task automatic popAndCheck();
        expEntry_t e;
        if (scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        checkOutput("cdb_valid", 64'(bus.cdb_valid), 64'(e.valid));
        checkOutput("cdb_tag",   64'(bus.cdb_tag),   64'(e.tag));
        checkOutput("cdb_data",  64'(bus.cdb_data),  64'(e.data));
        checkOutput("cdb_src",   64'(bus.cdb_src),   64'(e.src));
    endtask

    // One cycle: check last broadcast, drive new requests, check grant, queue expectation
    task automatic applyStimulus(input logic [7:0] valid, input logic fl);
        int g;
        expEntry_t e;
        logic [7:0] expReady;
        @(negedge clk);
        popAndCheck();
        bus.req_valid = valid;
        flush = fl;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_tag[i*TAG_W +: TAG_W]   = tagOf[i];
            bus.req_data[i*DATA_W +: DATA_W] = dataOf[i];
        end
        #1;
        g = fl ? -1 : modelGrant(valid);
        expReady = (g >= 0) ? (8'd1 << g) : 8'd0;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        if (g >= 0) begin
            mdlTag  = tagOf[g];
            mdlData = dataOf[g];
            mdlSrc  = 3'(g);
`ifndef CDB_AGE_PRIO_EN
            mdlRr   = (g + 1) % NUM_REQ;
`endif
        end
        e.valid = (g >= 0);
        e.tag   = mdlTag;
        e.data  = mdlData;
        e.src   = mdlSrc;
        scoreboard.push_back(e);
    endtask

    // Check the final queued broadcast and idle the requesters
    task automatic drainStep();
        @(negedge clk);
        popAndCheck();
        bus.req_valid = '0;
        flush = 1'b0;
    endtask

    // Reset with all requests raised; grants must stay off and outputs clear
    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 8'hFF;
        #1;
        checkOutput("ready_in_reset", 64'(bus.req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        scoreboard.delete();
        mdlRr = 0; mdlTag = '0; mdlData = '0; mdlSrc = '0;
        checkOutput("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        checkOutput("rst_cdb_tag",   64'(bus.cdb_tag),   64'h0);
        checkOutput("rst_cdb_data",  64'(bus.cdb_data),  64'h0);
        checkOutput("rst_cdb_src",   64'(bus.cdb_src),   64'h0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        robHead = 3'd0;
        bus.req_valid = '0;
        bus.req_tag = '0;
        bus.req_data = '0;
        mdlRr = 0; mdlTag = '0; mdlData = '0; mdlSrc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tagOf[i]  = 3'(i ^ 5);
            dataOf[i] = 32'hC0DE_0000 + 32'(i * 17);
        end

        // Single request on FU0, one broadcast next cycle
        resetDut();
        tagOf[0] = 3'd3;
        dataOf[0] = 32'hDEADBEEF;
        applyStimulus(8'h01, 1'b0);
        drainStep();

        // All requesters busy: grants sweep 0..7 with no gaps
        resetDut();
        for (int s = 0; s < 8; s++) applyStimulus(8'hFF, 1'b0);
        drainStep();

        // Sparse requests and wrap ordering
        resetDut();
        applyStimulus(8'h90, 1'b0);
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h10, 1'b0);
        drainStep();

        // Flush mid-stream: no grant that cycle, pointer unchanged afterwards
        resetDut();
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'h0F, 1'b0);
        applyStimulus(8'h0F, 1'b0);
        drainStep();

        // Back-to-back broadcasts from one lone requester, then an idle cycle holds payload
        resetDut();
        for (int s = 0; s < 3; s++) applyStimulus(8'h40, 1'b0);
        applyStimulus(8'h00, 1'b0);
        drainStep();

        // Reset while a broadcast is live clears it asynchronously
        resetDut();
        applyStimulus(8'h24, 1'b0);
        applyStimulus(8'h24, 1'b0);
        drainStep();
        rst = 1'b1;
        #1;
        checkOutput("async_rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        scoreboard.delete();
        mdlRr = 0; mdlTag = '0; mdlData = '0; mdlSrc = '0;
        applyStimulus(8'hFF, 1'b0);
        drainStep();

`ifdef CDB_AGE_PRIO_EN
        // Oldest tag first relative to the ROB head
        resetDut();
        robHead = 3'd6;
        tagOf[1] = 3'd7;
        tagOf[2] = 3'd1;
        tagOf[5] = 3'd6;
        applyStimulus(8'h26, 1'b0);
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h04, 1'b0);
        drainStep();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
